// File: rtl/addsub_rr_sched.sv
// Round-robin arbiter feeding one shared add/sub unit, one operation in flight.
// Accept cycle N -> response valid in cycle N+2; a stalled response blocks all new grants.
module addsub_rr_sched #(
  parameter int DATA_WD = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_WD   = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*DATA_WD-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_WD-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]         i_req_mode,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_WD-1:0]           o_rsp_id,
  output logic [DATA_WD:0]           o_rsp_result,
  output logic                       o_rsp_ovr,
  output logic                       o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_WD-1:0]   rr_ptr;
  logic [ID_WD-1:0]   ptr_nxt;
  logic [ID_WD-1:0]   gnt_idx;
  logic [ID_WD-1:0]   cand;
  logic               gnt_vld;
  logic               accept;
  logic [DATA_WD-1:0] op_a;
  logic [DATA_WD-1:0] op_b;
  logic               op_mode;
  logic [ID_WD-1:0]   op_id;
  logic [DATA_WD:0]   dp_result;
  logic               dp_ovr;

  // Search starts at the pointer and wraps, so NUM_REQ need not be a power of two.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_WD'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_vld && i_req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept  = (state == IDLE) && gnt_vld;
  assign ptr_nxt = ID_WD'((int'(gnt_idx) + 1) % NUM_REQ);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset directly so it is low during reset without waiting for a clock.
  always_comb begin
    o_req_ready = '0;
    if ((state == IDLE) && gnt_vld && i_rst_n) begin
      o_req_ready = NUM_REQ'(1) << gnt_idx;
    end
    o_busy      = (state != IDLE);
    o_rsp_valid = (state == RESP);
  end

  // Overflow is judged on the DATA_WD-bit result; the extra MSB is the carry/borrow.
  always_comb begin
    if (op_mode) begin
      dp_result = {1'b0, op_a} - {1'b0, op_b};
      dp_ovr    = (op_a[DATA_WD-1] != op_b[DATA_WD-1]) && (dp_result[DATA_WD-1] != op_a[DATA_WD-1]);
    end else begin
      dp_result = {1'b0, op_a} + {1'b0, op_b};
      dp_ovr    = (op_a[DATA_WD-1] == op_b[DATA_WD-1]) && (dp_result[DATA_WD-1] != op_a[DATA_WD-1]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_mode      <= 1'b0;
      op_id        <= '0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      o_rsp_ovr    <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= i_req_a[gnt_idx*DATA_WD +: DATA_WD];
        op_b    <= i_req_b[gnt_idx*DATA_WD +: DATA_WD];
        op_mode <= i_req_mode[gnt_idx];
        op_id   <= gnt_idx;
        rr_ptr  <= ptr_nxt;
      end
      if (state == EXEC) begin
        o_rsp_id     <= op_id;
        o_rsp_result <= dp_result;
        o_rsp_ovr    <= dp_ovr;
      end
    end
  end

endmodule

// File: doc/addsub_rr_sched.md
Name: addsub_rr_sched

Overview:
- Round-robin scheduler that shares one programmable add/sub datapath between NUM_REQ requesters.
- Each requester has a valid/ready request port; one shared response port returns result, overflow flag and requester ID.
- Sits between client blocks and the arithmetic unit; only one operation is in flight at a time.

Parameters:
- DATA_WD, 4, operand width in bits
- NUM_REQ, 4, number of requesters (2..8)
- ID_WD, $clog2(NUM_REQ), width of response ID (derived; do not override)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- i_req_a  in  NUM_REQ*DATA_WD  operand A; requester k uses bits [k*DATA_WD +: DATA_WD]
- i_req_b  in  NUM_REQ*DATA_WD  operand B; same packing as i_req_a
- i_req_mode  in  NUM_REQ  0 = add, 1 = subtract (A-B)
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumer ready
- o_rsp_id  out  ID_WD  index of the requester that owns the response
- o_rsp_result  out  DATA_WD+1  arithmetic result
- o_rsp_ovr  out  1  signed overflow flag
- o_busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE, rr pointer = 0.
  - o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_ovr, o_busy all 0.
  - o_req_ready = 0 while i_rst_n is low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with valid set, searching from the rr pointer upward and wrapping modulo NUM_REQ.
  - o_req_ready[grant] = 1 combinationally; all other ready bits are 0.
  - No valid requesters: all ready bits 0, stay in IDLE.
  - On valid & ready: latch a, b, mode and grant index; set rr pointer = grant+1 mod NUM_REQ; go to EXEC.
- EXEC (one cycle):
  - The datapath evaluates the latched operands.
  - result = {1'b0,A} + {1'b0,B} for add, or {1'b0,A} - {1'b0,B} for subtract, truncated to DATA_WD+1 bits.
  - ovr = two's-complement overflow of the DATA_WD-bit operation:
    - add: sign(A) == sign(B) and sign(sum) != sign(A).
    - subtract: sign(A) != sign(B) and sign(diff) != sign(A).
  - Register result, ovr and ID into the response registers; go to RESP.
- RESP:
  - o_rsp_valid = 1; all response fields hold stable until i_rsp_ready = 1.
  - In the handshake cycle, go to IDLE; o_rsp_valid drops the next cycle.
  - o_req_ready is 0 in EXEC and RESP.
- Latency: accept edge N → o_rsp_valid high after edge N+2. Minimum 3 cycles per operation.
- Requester inputs are sampled only in the accept cycle; later changes do not affect the in-flight operation.
- Backpressure: i_rsp_ready held low stalls indefinitely in RESP; no request is accepted meanwhile.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- A requester that drops valid before being granted is simply skipped. Valid may not be withdrawn in a cycle where ready is high.
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and the rr pointer returns to 0.

Test Plan:
- Reset, then req0 valid, a=7, b=1, mode=0 → ready0 in the same cycle; 2 cycles later rsp_valid, id=0, result=5'h08, ovr=1.
- req2 a=3, b=5, mode=1 → id=2, result=5'h1E, ovr=0. Then req1 a=8, b=1, mode=1 → id=1, result=5'h07, ovr=1.
- All four requesters valid continuously with rsp_ready=1 → grant/id order 0,1,2,3,0,1; exactly one ready bit per accept; 3-cycle spacing between accepts.
- rsp_ready held 0 for 5 cycles in RESP with req3 valid → response fields stable, o_req_ready=0 throughout; req3 accepted only after the response handshake.
- Pointer at 2, only req0 and req1 valid → req0 granted first (wrap), then req1.
- Assert i_rst_n low during EXEC → outputs 0 immediately; no response after release; next grant starts from requester 0.
